// File: rtl/dot_seq_ctrl.sv
// Dot-product sequencer: fetches N operand pairs, streams them into an external MAC and returns the sum.
// Optional macro DOT_SEQ_RELU_EN clamps a negative (two's complement) accumulator to zero at capture.
module dot_seq_ctrl #(
  parameter int INPUT_WIDTH       = 8,
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int ADDR_WIDTH        = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        len,
  input  logic [ADDR_WIDTH-1:0]        base_a,
  input  logic [ADDR_WIDTH-1:0]        base_b,
  output logic                         busy,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr_a,
  output logic [ADDR_WIDTH-1:0]        rd_addr_b,
  input  logic [INPUT_WIDTH-1:0]       rd_data_a,
  input  logic [INPUT_WIDTH-1:0]       rd_data_b,
  output logic                         mac_rst,
  output logic [INPUT_WIDTH-1:0]       mac_a,
  output logic [INPUT_WIDTH-1:0]       mac_b,
  input  logic [ACCUMULATOR_WIDTH-1:0] mac_p,
  output logic [ACCUMULATOR_WIDTH-1:0] result_data,
  output logic                         result_valid,
  input  logic                         result_ready
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t                         state;
  state_t                         next_state;
  logic [ADDR_WIDTH-1:0]          len_q;
  logic [ADDR_WIDTH-1:0]          base_a_q;
  logic [ADDR_WIDTH-1:0]          base_b_q;
  logic [ADDR_WIDTH-1:0]          k;
  logic [1:0]                     drain_cnt;
  logic                           data_vld;
  logic [ACCUMULATOR_WIDTH-1:0]   capture;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CLEAR;
      CLEAR:   next_state = (len_q != '0) ? FETCH : DRAIN;
      FETCH:   if (k == len_q - ADDR_WIDTH'(1)) next_state = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) next_state = DONE;
      DONE:    if (result_valid && result_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    rd_en     = (state == FETCH);
    rd_addr_a = base_a_q + k;
    rd_addr_b = base_b_q + k;
    mac_rst   = reset || (state == CLEAR);
  end

`ifdef DOT_SEQ_RELU_EN
  always_comb begin
    capture = mac_p[ACCUMULATOR_WIDTH-1] ? '0 : mac_p;
  end
`else
  always_comb begin
    capture = mac_p;
  end
`endif

  // result_valid rises one cycle after the DONE-entry capture, so the first DONE cycle never handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len_q        <= '0;
      base_a_q     <= '0;
      base_b_q     <= '0;
      k            <= '0;
      drain_cnt    <= '0;
      data_vld     <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      result_data  <= '0;
      result_valid <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        len_q    <= len;
        base_a_q <= base_a;
        base_b_q <= base_b;
        k        <= '0;
      end else if (state == FETCH) begin
        k <= k + ADDR_WIDTH'(1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      data_vld  <= rd_en;
      mac_a     <= data_vld ? rd_data_a : '0;
      mac_b     <= data_vld ? rd_data_b : '0;
      if (state == DRAIN && next_state == DONE) begin
        result_data <= capture;
      end
      result_valid <= (state == DONE) && !(result_valid && result_ready);
    end
  end

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Scoreboard bench for dot_seq_ctrl with behavioural operand memories and MAC.
module tb_dot_seq_ctrl;
`ifdef DOT_SEQ_RELU_EN
  localparam int AW = 8;
`else
  localparam int AW = 32;
`endif
  localparam int IW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] len, base_a, base_b;
  logic          busy, rd_en, mac_rst, result_valid, result_ready;
  logic [DW-1:0] rd_addr_a, rd_addr_b;
  logic [IW-1:0] rd_data_a, rd_data_b, mac_a, mac_b;
  logic [AW-1:0] mac_p, result_data;

  dot_seq_ctrl #(.INPUT_WIDTH(IW), .ACCUMULATOR_WIDTH(AW), .ADDR_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .base_a(base_a), .base_b(base_b),
    .busy(busy), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .mac_rst(mac_rst), .mac_a(mac_a),
    .mac_b(mac_b), .mac_p(mac_p), .result_data(result_data), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand memories: one-cycle read latency, garbage when not reading.
  logic [IW-1:0] mem_a [256];
  logic [IW-1:0] mem_b [256];
  always @(posedge clk) begin
    rd_data_a <= rd_en ? mem_a[rd_addr_a] : IW'($urandom);
    rd_data_b <= rd_en ? mem_b[rd_addr_b] : IW'($urandom);
  end

  always @(posedge clk) begin
    if (mac_rst) mac_p <= '0;
    else         mac_p <= mac_p + AW'(mac_a) * AW'(mac_b);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [AW-1:0] exp_res_q [$];
  int            exp_cyc_q [$];
  logic [DW-1:0] exp_addr_a_q [$];
  logic [DW-1:0] exp_addr_b_q [$];
  logic          prev_valid = 1'b0;
  logic [AW-1:0] held;
  int            valid_cycles = 0;

  always @(negedge clk) begin
    if (rd_en) begin
      if (exp_addr_a_q.size() == 0) chk("rd_en_no_pending", rd_en, 1'b0);
      else begin
        chk("rd_addr_a", rd_addr_a, exp_addr_a_q.pop_front());
        chk("rd_addr_b", rd_addr_b, exp_addr_b_q.pop_front());
      end
    end
    if (result_valid) valid_cycles++;
    if (result_valid && !prev_valid) begin
      if (exp_res_q.size() == 0) chk("result_unexpected", result_valid, 1'b0);
      else begin
        chk("latency", cyc, exp_cyc_q.pop_front());
        chk("result_data", result_data, exp_res_q.pop_front());
      end
      held = result_data;
    end else if (result_valid && prev_valid) begin
      chk("result_stable", result_data, held);
    end
    prev_valid = result_valid;
  end

  logic [IW-1:0] va [16];
  logic [IW-1:0] vb [16];

  task automatic launch(input int n, input logic [DW-1:0] ba, input logic [DW-1:0] bb,
                        input int n_addr, input bit want_result);
    logic [AW-1:0] s;
    logic [DW-1:0] ia, ib;
    s = '0;
    for (int i = 0; i < n; i++) begin
      ia = ba + DW'(i);
      ib = bb + DW'(i);
      mem_a[ia] = va[i];
      mem_b[ib] = vb[i];
      s = s + AW'(va[i]) * AW'(vb[i]);
      if (i < n_addr) begin
        exp_addr_a_q.push_back(ia);
        exp_addr_b_q.push_back(ib);
      end
    end
`ifdef DOT_SEQ_RELU_EN
    if (s[AW-1]) s = '0;
`endif
    @(negedge clk);
    start = 1'b1; len = DW'(n); base_a = ba; base_b = bb;
    @(posedge clk); #1;
    if (want_result) begin
      exp_res_q.push_back(s);
      exp_cyc_q.push_back(cyc + n + 5);
    end
    @(negedge clk);
    start = 1'b0; len = DW'($urandom); base_a = DW'($urandom); base_b = DW'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("job_timeout_busy", busy, 1'b0);
  endtask

  int vc0;
  int n;

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; base_a = '0; base_b = '0; result_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_addr_a", rd_addr_a, '0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_data", result_data, '0);
    chk("rst_mac_rst", mac_rst, 1'b1);
    chk("rst_mac_a", mac_a, '0);
    chk("rst_mac_b", mac_b, '0);
    reset = 1'b0;

    // Basic 4-term product: 1*5+2*6+3*7+4*8 = 70, valid for one cycle.
    va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
    vb[0] = 5; vb[1] = 6; vb[2] = 7; vb[3] = 8;
    vc0 = valid_cycles;
    launch(4, 8'h10, 8'h40, 4, 1'b1);
    wait_idle();
    chk("valid_one_cycle", valid_cycles - vc0, 1);
    chk("sum70_data", result_data, AW'(70));

    // Empty job.
    launch(0, 8'h20, 8'h30, 0, 1'b1);
    wait_idle();

    // Address wrap on A.
    for (int i = 0; i < 4; i++) begin va[i] = IW'($urandom); vb[i] = IW'($urandom); end
    launch(4, 8'hFE, 8'h80, 4, 1'b1);
    wait_idle();

    for (int j = 0; j < 3; j++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < 16; i++) begin va[i] = IW'($urandom); vb[i] = IW'($urandom); end
      launch(n, DW'($urandom), DW'($urandom), n, 1'b1);
      wait_idle();
    end

    // Back-pressure: hold ready low, pulse start while DONE, release with start high.
    result_ready = 1'b0;
    va[0] = 9; va[1] = 8; va[2] = 7; vb[0] = 1; vb[1] = 2; vb[2] = 3;
    launch(3, 8'h00, 8'h00, 3, 1'b1);
    for (int i = 0; i < 60; i++) begin
      if (result_valid) break;
      @(negedge clk);
    end
    chk("stall_valid_seen", result_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3); len = 8'd5;
      @(negedge clk);
      chk("stall_busy", busy, 1'b1);
      chk("stall_valid", result_valid, 1'b1);
    end
    result_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("handshake_idle", busy, 1'b0);
    @(negedge clk);
    chk("no_new_job", busy, 1'b0);

    // Abort mid-fetch at k=2 of 8.
    for (int i = 0; i < 8; i++) begin va[i] = IW'($urandom); vb[i] = IW'($urandom); end
    launch(8, 8'h50, 8'h60, 3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (rd_en && rd_addr_a == 8'h52) break;
      @(negedge clk);
    end
    chk("abort_at_k2", rd_addr_a, 8'h52);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", result_valid, 1'b0);
    chk("abort_rd_en", rd_en, 1'b0);
    chk("abort_mac_rst", mac_rst, 1'b1);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("abort_stays_idle", busy, 1'b0);
    va[0] = 3; vb[0] = 3;
    launch(1, 8'h05, 8'h06, 1, 1'b1);
    wait_idle();
    chk("after_abort_9", result_data, AW'(9));

`ifdef DOT_SEQ_RELU_EN
    va[0] = 200; va[1] = 100; vb[0] = 1; vb[1] = 1;
    launch(2, 8'h00, 8'h00, 2, 1'b1);
    wait_idle();
    chk("relu_pos_44", result_data, AW'(44));
    va[0] = 200; vb[0] = 1;
    launch(1, 8'h00, 8'h00, 1, 1'b1);
    wait_idle();
    chk("relu_neg_0", result_data, AW'(0));
`endif

    repeat (3) @(negedge clk);
    chk("results_outstanding", exp_res_q.size(), 0);
    chk("addrs_outstanding", exp_addr_a_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dot_seq_ctrl.md
DOT_SEQ_CTRL -- requirements
Module: dot_seq_ctrl

Interface
REQ-001 Parameter INPUT_WIDTH, default 8: operand width driven to the MAC.
REQ-002 Parameter ACCUMULATOR_WIDTH, default 32: MAC accumulator / result width.
REQ-003 Parameter ADDR_WIDTH, default 8: operand memory address width and `len` width.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  job request; accepted only when busy=0.
REQ-007 len  input  ADDR_WIDTH  number of product terms N; sampled on acceptance.
REQ-008 base_a, base_b  input  ADDR_WIDTH each  start addresses of operand vectors A and B; sampled on acceptance.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 rd_en  output  1  operand memory read strobe.
REQ-011 rd_addr_a, rd_addr_b  output  ADDR_WIDTH each  read addresses.
REQ-012 rd_data_a, rd_data_b  input  INPUT_WIDTH each  read data; valid exactly 1 cycle after the rd_en cycle.
REQ-013 mac_rst  output  1  drives the MAC reset (clears the accumulator).
REQ-014 mac_a, mac_b  output  INPUT_WIDTH each  registered MAC operands.
REQ-015 mac_p  input  ACCUMULATOR_WIDTH  MAC accumulator value.
REQ-016 result_data  output  ACCUMULATOR_WIDTH  dot-product result.
REQ-017 result_valid / result_ready  output / input  1 each  result handshake.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, FETCH, DRAIN and DONE.
REQ-019 IDLE -> CLEAR when start=1; capture len, base_a and base_b; clear the term counter k.
REQ-020 CLEAR lasts 1 cycle with mac_rst=1; mac_rst=0 in all other non-reset states. Next state is FETCH if N>0, else DRAIN.
REQ-021 FETCH lasts N cycles: rd_en=1, rd_addr_a=base_a+k, rd_addr_b=base_b+k, k incrementing each cycle; addresses wrap modulo 2^ADDR_WIDTH.
REQ-022 A 1-bit valid pipeline follows rd_en. The cycle after returned data is valid, mac_a/mac_b SHALL equal rd_data_a/rd_data_b; otherwise mac_a=mac_b=0, so the MAC accumulates zero.
REQ-023 DRAIN lasts exactly 3 cycles, then DONE; on entry to DONE, result_data is captured from mac_p.
REQ-024 result_valid=1 only in DONE; result_data SHALL be held stable until result_valid and result_ready are both high in the same cycle, then DONE -> IDLE.
REQ-025 Latency: with start accepted at edge 0, result_valid SHALL rise after edge N+5 (N=0 gives edge 5).
REQ-026 start SHALL be ignored in all states other than IDLE, including DONE and the handshake cycle; a new start is accepted at the earliest on the cycle after returning to IDLE.
REQ-027 Products and the sum are unsigned modulo 2^ACCUMULATOR_WIDTH, as produced by the MAC; the controller performs no arithmetic on mac_p except REQ-033.

Reset
REQ-028 While reset=1: state=IDLE, busy=0, rd_en=0, addresses=0, mac_a=mac_b=0, result_valid=0, result_data=0, k=0, valid pipeline cleared.
REQ-029 While reset=1, mac_rst SHALL be 1.
REQ-030 Reset asserted mid-job in any state SHALL abort the job with no result delivered; start is ignored while reset=1.

Configuration
REQ-031 The feature is controlled by macro DOT_SEQ_RELU_EN.
REQ-032 With DOT_SEQ_RELU_EN undefined: result_data = mac_p unmodified.
REQ-033 With DOT_SEQ_RELU_EN defined: at capture, mac_p is read as two's complement; if its MSB=1, result_data=0, otherwise result_data=mac_p.

Verification
REQ-034 N=4, A=[1,2,3,4], B=[5,6,7,8], result_ready=1 -> result_data=70; result_valid rises after edge 9, high for exactly 1 cycle.
REQ-035 N=0 -> result_data=0, result_valid after edge 5, rd_en never asserted.
REQ-036 base_a=0xFE, N=4 -> rd_addr_a sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-037 result_ready held 0 for 10 cycles in DONE, with start pulsed during that time -> result_data stable, busy=1, no new job; completes on ready.
REQ-038 reset pulsed during FETCH at k=2 of N=8 -> next cycle IDLE, busy=0, result_valid=0; a following job with N=1, A=[3], B=[3] -> 9.
REQ-039 DOT_SEQ_RELU_EN defined, ACCUMULATOR_WIDTH=8, N=2, A=[200,100], B=[1,1] -> mac_p=0x2C, result 44; with N=1, A=[200], B=[1] -> result 0.
